div_unit: RTL



---
 rtl/div_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: result_o = {remainder, quotient}.
// Optional macro DIV_ZERO_FLAG_EN adds a registered div_zero_o flag for divide-by-zero results.
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   input  logic        start_i,
   input  logic        annul_i,
   output logic [63:0] result_o,
   output logic        ready_o
`ifdef DIV_ZERO_FLAG_EN
   ,
   output logic        div_zero_o
`endif
);

   localparam logic [1:0] S_FREE   = 2'b00;
   localparam logic [1:0] S_BYZERO = 2'b01;
   localparam logic [1:0] S_ON     = 2'b10;
   localparam logic [1:0] S_END    = 2'b11;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return (~v) + 32'd1;
   endfunction

   logic [1:0]  r_state;
   logic [5:0]  r_cnt;
   logic [64:0] r_work;
   logic [31:0] r_divisor;
   logic        r_neg_q;
   logic        r_neg_r;

   logic [31:0] w_mag1;
   logic [31:0] w_mag2;
   logic [32:0] w_trial;
   logic [31:0] w_quot;
   logic [31:0] w_rem;

   // Operand magnitudes, trial subtraction and sign-corrected final result.
   always_comb begin
      w_mag1  = opdata1_i;
      w_mag2  = opdata2_i;
      if (signed_div_i && opdata1_i[31]) begin
         w_mag1 = neg32(opdata1_i);
      end else begin
         w_mag1 = opdata1_i;
      end
      if (signed_div_i && opdata2_i[31]) begin
         w_mag2 = neg32(opdata2_i);
      end else begin
         w_mag2 = opdata2_i;
      end
      w_trial = r_work[64:32] - {1'b0, r_divisor};
      if (r_neg_q) begin
         w_quot = neg32(r_work[31:0]);
      end else begin
         w_quot = r_work[31:0];
      end
      if (r_neg_r) begin
         w_rem = neg32(r_work[64:33]);
      end else begin
         w_rem = r_work[64:33];
      end
   end

   // Control FSM, iteration datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_FREE;
         r_cnt     <= 6'd0;
         r_work    <= 65'd0;
         r_divisor <= 32'd0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         result_o  <= 64'd0;
         ready_o   <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
         div_zero_o <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_FREE: begin
               result_o <= 64'd0;
               ready_o  <= 1'b0;
               if (start_i && !annul_i) begin
                  if (opdata2_i == 32'd0) begin
                     r_state <= S_BYZERO;
                  end else begin
                     r_state   <= S_ON;
                     r_divisor <= w_mag2;
                     r_work    <= {32'd0, w_mag1, 1'b0};
                     r_cnt     <= 6'd0;
                     r_neg_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                     r_neg_r   <= signed_div_i & opdata1_i[31];
                  end
               end else begin
                  r_state <= S_FREE;
               end
            end
            S_BYZERO: begin
               if (annul_i) begin
                  r_state <= S_FREE;
               end else begin
                  r_state  <= S_END;
                  result_o <= 64'd0;
                  ready_o  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                  div_zero_o <= 1'b1;
`endif
               end
            end
            S_ON: begin
               if (annul_i || !start_i) begin
                  r_state  <= S_FREE;
                  result_o <= 64'd0;
                  ready_o  <= 1'b0;
               end else if (r_cnt != 6'd32) begin
                  // The concatenation already shifts left by one: partial remainder moves up, quotient bit enters at [0].
                  if (w_trial[32]) begin
                     r_work <= {r_work[63:0], 1'b0};
                  end else begin
                     r_work <= {w_trial[31:0], r_work[31:0], 1'b1};
                  end
                  r_cnt <= r_cnt + 6'd1;
               end else begin
                  r_state  <= S_END;
                  result_o <= {w_rem, w_quot};
                  ready_o  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                  div_zero_o <= 1'b0;
`endif
               end
            end
            S_END: begin
               if (!start_i || annul_i) begin
                  r_state  <= S_FREE;
                  result_o <= 64'd0;
                  ready_o  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
                  div_zero_o <= 1'b0;
`endif
               end else begin
                  r_state <= S_END;
               end
            end
            default: begin
               r_state  <= S_FREE;
               result_o <= 64'd0;
               ready_o  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
               div_zero_o <= 1'b0;
`endif
            end
         endcase
      end
   end

endmodule
